// File: rtl/fp_exp_issue_ctrl.sv
// Issue/collect controller in front of the fp32 exp unit: buffers samples in a FIFO,
// launches one exp op at a time, and registers each result behind a valid/ready port.
module fp_exp_issue_ctrl #(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TIMEOUT = 32
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [31:0]            in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [31:0]            out_data,
   output logic                   exp_clk_en,
   output logic [31:0]            exp_dataa,
   input  logic [31:0]            exp_result,
   input  logic                   exp_done,
   output logic                   busy,
   output logic                   err_timeout,
   output logic [$clog2(DEPTH):0] fifo_level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam int unsigned CW = $clog2(TIMEOUT + 1);
   localparam logic [LW-1:0] C_FULL       = LW'(DEPTH);
   localparam logic [CW-1:0] C_FLUSH_LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] C_WAIT_LAST  = CW'(TIMEOUT - 2);

   typedef enum logic [1:0] {
      S_FLUSH,
      S_IDLE,
      S_ISSUE,
      S_WAIT
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;

   logic [31:0]   r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [LW-1:0] r_level;
   logic [CW-1:0] r_cnt;
   logic          r_out_valid;
   logic [31:0]   r_out_data;
   logic [31:0]   r_dataa;
   logic          r_err;

   logic          w_push;
   logic          w_pop;
   logic          w_full;
   logic          w_empty;
   logic          w_capture;
   logic          w_timeout;

   assign w_full  = (r_level == C_FULL);
   assign w_empty = (r_level == '0);
   assign w_push  = in_valid && !w_full;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_FLUSH;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_capture   = 1'b0;
      w_timeout   = 1'b0;
      case (r_state)
         S_FLUSH: begin
            if (r_cnt == C_FLUSH_LAST) begin
               w_state_nxt = S_IDLE;
            end
         end
         S_IDLE: begin
            if (!w_empty && (!r_out_valid || out_ready)) begin
               w_pop       = 1'b1;
               w_state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            // Deciding in the last WAIT cycle makes err_timeout rise TIMEOUT edges after ISSUE.
            if (exp_done) begin
               w_capture   = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (r_cnt == C_WAIT_LAST) begin
               w_timeout   = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_FLUSH;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt <= '0;
      end else begin
         case (r_state)
            S_FLUSH: r_cnt <= (r_cnt == C_FLUSH_LAST) ? '0 : r_cnt + 1'b1;
            S_ISSUE: r_cnt <= '0;
            S_WAIT:  r_cnt <= r_cnt + 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_dataa     <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_err       <= 1'b0;
      end else begin
         if (w_pop) begin
            r_dataa <= r_mem[r_rd_ptr];
         end
         if (w_capture) begin
            r_out_valid <= 1'b1;
            r_out_data  <= exp_result;
         end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
         end
         if (w_timeout) begin
            r_err <= 1'b1;
         end
      end
   end

   assign in_ready    = !w_full;
   assign out_valid   = r_out_valid;
   assign out_data    = r_out_data;
   assign exp_clk_en  = (r_state == S_ISSUE);
   assign exp_dataa   = r_dataa;
   assign busy        = (r_state != S_IDLE);
   assign err_timeout = r_err;
   assign fifo_level  = r_level;

endmodule
